// File: rtl/alu_checker_if.sv
// Stimulus/result bus between the ALU test sequencer (master) and alu_checker (slave).
interface alu_checker_if #(
  parameter int CNT_W = 8
);
  logic             vld;
  logic [6:0]       A;
  logic [6:0]       B;
  logic [1:0]       OP;
  logic             done;
  logic [6:0]       R;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             report_valid;
  logic             all_pass;
  logic             ff_valid;
  logic [6:0]       ff_A;
  logic [6:0]       ff_B;
  logic [1:0]       ff_OP;
  logic [6:0]       ff_R;
  logic [6:0]       ff_exp;

  modport master (
    output vld, A, B, OP, done, R,
    input  pass, fail, pass_cnt, fail_cnt, report_valid, all_pass,
    input  ff_valid, ff_A, ff_B, ff_OP, ff_R, ff_exp
  );

  modport slave (
    input  vld, A, B, OP, done, R,
    output pass, fail, pass_cnt, fail_cnt, report_valid, all_pass,
    output ff_valid, ff_A, ff_B, ff_OP, ff_R, ff_exp
  );
endinterface

// File: rtl/alu_checker.sv
// Response checker for the 7-bit NAND/ROL ALU; expected values ride a RES_LAT-deep pipe to meet R.
// No backpressure: one vector per cycle. First-failure capture enabled by ALU_CHECKER_FAIL_LOG_EN.
module alu_checker #(
  parameter int RES_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_checker_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CHECK, DRAIN, REPORT} state_t;

  typedef struct packed {
    logic       v;
    logic       ill;
    logic [6:0] exp;
`ifdef ALU_CHECKER_FAIL_LOG_EN
    logic [6:0] a;
    logic [6:0] b;
    logic [1:0] op;
`endif
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [1:0]       LAT_INIT = 2'(RES_LAT);

  state_t           state, state_nxt;
  logic [1:0]       drn_cnt, drn_cnt_nxt;
  logic             accept;
  logic [2:0]       amt;
  logic [6:0]       exp_c;
  stage_t           stg_in, stg_out;
  logic             hit, mis;
  logic             pass_q, fail_q;
  logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q;
  logic             report;

  assign accept = bus.vld && (state == IDLE || state == CHECK);
  assign amt    = bus.B[2:0];

  always_comb begin
    exp_c = '0;
    case (bus.OP)
      2'b00:   exp_c = ~(bus.A & bus.B);
      2'b01:   exp_c = (bus.A << amt) | (bus.A >> (3'd7 - amt));
      default: exp_c = '0;
    endcase
  end

  always_comb begin
    stg_in     = '0;
    stg_in.v   = accept;
    stg_in.ill = bus.OP[1];
    stg_in.exp = exp_c;
`ifdef ALU_CHECKER_FAIL_LOG_EN
    stg_in.a   = bus.A;
    stg_in.b   = bus.B;
    stg_in.op  = bus.OP;
`endif
  end

  // Zero latency means the ALU answers in the same cycle, so compare straight off the inputs.
  if (RES_LAT == 0) begin : g_nopipe
    assign stg_out = stg_in;
  end else begin : g_pipe
    stage_t pipe_q [RES_LAT];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < RES_LAT; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= stg_in;
        for (int i = 1; i < RES_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign stg_out = pipe_q[RES_LAT-1];
  end

  assign mis = stg_out.v && (stg_out.ill || (bus.R != stg_out.exp));
  assign hit = stg_out.v && !mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_q <= hit;
      fail_q <= mis;
      if (hit && pass_cnt_q != CNT_MAX) pass_cnt_q <= pass_cnt_q + CNT_W'(1);
      if (mis && fail_cnt_q != CNT_MAX) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      drn_cnt <= '0;
    end else begin
      state   <= state_nxt;
      drn_cnt <= drn_cnt_nxt;
    end
  end

  // DRAIN waits out the pipe so every vector accepted up to done is counted before REPORT.
  always_comb begin
    state_nxt   = state;
    drn_cnt_nxt = drn_cnt;
    case (state)
      IDLE: begin
        if (bus.done) begin
          state_nxt   = DRAIN;
          drn_cnt_nxt = LAT_INIT;
        end else if (bus.vld) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (bus.done) begin
          state_nxt   = DRAIN;
          drn_cnt_nxt = LAT_INIT;
        end
      end
      DRAIN: begin
        if (drn_cnt == 2'd0) state_nxt = REPORT;
        else                 drn_cnt_nxt = drn_cnt - 2'd1;
      end
      REPORT:  state_nxt = REPORT;
      default: state_nxt = IDLE;
    endcase
  end

  assign report           = (state == REPORT);
  assign bus.pass         = pass_q;
  assign bus.fail         = fail_q;
  assign bus.pass_cnt     = pass_cnt_q;
  assign bus.fail_cnt     = fail_cnt_q;
  assign bus.report_valid = report;
  assign bus.all_pass     = report && (fail_cnt_q == '0) && (pass_cnt_q != '0);

`ifdef ALU_CHECKER_FAIL_LOG_EN
  logic       ff_valid_q;
  logic [6:0] ff_a_q, ff_b_q, ff_r_q, ff_exp_q;
  logic [1:0] ff_op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_valid_q <= 1'b0;
      ff_a_q     <= '0;
      ff_b_q     <= '0;
      ff_op_q    <= '0;
      ff_r_q     <= '0;
      ff_exp_q   <= '0;
    end else if (mis && !ff_valid_q) begin
      ff_valid_q <= 1'b1;
      ff_a_q     <= stg_out.a;
      ff_b_q     <= stg_out.b;
      ff_op_q    <= stg_out.op;
      ff_r_q     <= bus.R;
      ff_exp_q   <= stg_out.exp;
    end
  end

  assign bus.ff_valid = ff_valid_q;
  assign bus.ff_A     = ff_a_q;
  assign bus.ff_B     = ff_b_q;
  assign bus.ff_OP    = ff_op_q;
  assign bus.ff_R     = ff_r_q;
  assign bus.ff_exp   = ff_exp_q;
`else
  assign bus.ff_valid = 1'b0;
  assign bus.ff_A     = '0;
  assign bus.ff_B     = '0;
  assign bus.ff_OP    = '0;
  assign bus.ff_R     = '0;
  assign bus.ff_exp   = '0;
`endif

endmodule

// File: doc/alu_checker.md
# alu_checker

Self-checking response monitor for the 7-bit NAND/ROL ALU. It sits on the consumer side of the stimulus bus that the ALU test sequencer drives (A, B, OP, done). It computes the expected result for every accepted vector and aligns it with the ALU result through a configurable latency pipe, then compares, counts passes and failures, and issues a final pass/fail report once the sequencer signals done and the pipe has drained.

## Interface
- RES_LAT, 1, ALU result latency in cycles from vector to R. Legal range 0..3.
- CNT_W, 8, width of the pass and fail counters.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- vld  in  1  the A/B/OP vector on this cycle is a real test vector.
- A  in  7  operand A.
- B  in  7  operand B.
- OP  in  2  opcode: 00 = NAND, 01 = ROL, 10/11 are illegal.
- done  in  1  sequencer finished. Treated as a level; the first high is used.
- R  in  7  ALU result.
- pass  out  1  one-cycle pulse when a compare matches.
- fail  out  1  one-cycle pulse when a compare mismatches or the opcode was illegal.
- pass_cnt  out  CNT_W  saturating count of matches.
- fail_cnt  out  CNT_W  saturating count of failures.
- report_valid  out  1  the final report is available. Held high.
- all_pass  out  1  valid only while report_valid is high: fail_cnt == 0 and pass_cnt != 0.
- ff_valid, ff_A[6:0], ff_B[6:0], ff_OP[1:0], ff_R[6:0], ff_exp[6:0]  out  first-failure capture (see Configuration).

## Operation
- Expected result:
  - NAND: ~(A & B), 7 bits.
  - ROL: A rotated left by B[2:0]. An amount of 7 gives A unchanged. B[6:3] are ignored.
  - Illegal OP: expected value 0, and an illegal flag travels with the vector.
- Latency pipe: expected value, illegal flag and vld are delayed RES_LAT stages. With RES_LAT = 0 the compare is combinational against the same-cycle R.
- Compare at pipe output when the delayed vld is 1:
  - Illegal, or R != exp: fail pulse, and fail_cnt increments.
  - Otherwise: pass pulse, and pass_cnt increments.
  - Counters saturate at 2^CNT_W-1. They never wrap.
- FSM states:
  - IDLE: no vector seen yet. vld goes to CHECK. done goes to DRAIN.
  - CHECK: vectors accepted. done goes to DRAIN.
  - DRAIN: vld is ignored. A down-counter loaded with RES_LAT goes to REPORT when it reaches 0. With RES_LAT = 0, DRAIN lasts one cycle.
  - REPORT: report_valid = 1. This state is terminal until reset. vld and done are ignored.
- vld and done in the same cycle: that vector is accepted and counted, and the FSM enters DRAIN.
- done while in IDLE: the report carries pass_cnt = 0, so all_pass = 0.
- Reset mid-operation clears the pipe, counters, capture and FSM immediately. In-flight compares are discarded.

## Timing
- Reset values: pass = fail = 0, pass_cnt = fail_cnt = 0, report_valid = all_pass = 0, all ff_* = 0, FSM in IDLE, pipe empty.
- pass and fail are registered.
- Vector accepted at edge t: pass or fail is high in the cycle after edge t+RES_LAT, and counters show the update in that same cycle.
- done sampled at edge d:
  - report_valid rises in the cycle after edge d+RES_LAT+1.
  - By then every vector accepted at or before d has been counted.
- pass and fail are never high together.
- Back-to-back vld on every cycle is supported at full throughput.

## Configuration
- ALU_CHECKER_FAIL_LOG_EN defined:
  - On the first failure after reset, ff_A, ff_B, ff_OP, ff_R and ff_exp latch that vector's values (A, B and OP are delayed alongside the pipe), and ff_valid is set to 1.
  - Later failures do not overwrite the capture.
- ALU_CHECKER_FAIL_LOG_EN undefined: no capture registers exist, and all ff_* outputs are tied to 0.

## Test plan
- RES_LAT = 1. Vectors A = 1010101, B = 0101010, OP = 00 with R = 1111111; then A = 1110000, B = 0000011, OP = 01 with R = 0000111; then A = 0, B = 0000001, OP = 00 with R = 1111111; then done -> three pass pulses, pass_cnt = 3, fail_cnt = 0, report_valid 2 cycles after done, all_pass = 1.
- ROL with A = 1000001, B = 0000111 and R = 1000001 -> pass. Same vector with B = 0001001 (amount 1) and R = 0000011 -> pass.
- NAND A = 1111111, B = 1111111 with wrong R = 0000001 -> fail pulse, fail_cnt = 1, all_pass = 0. With the macro defined: ff_exp = 0000000, ff_R = 0000001, ff_valid = 1.
- OP = 10 with any R -> fail. vld and done in the same cycle -> that vector is still counted before report_valid rises.
- 300 passing vectors with CNT_W = 8 -> pass_cnt holds at 255. Assert rst_n low during a stream -> all outputs return to 0 asynchronously, and no pass pulse appears after release.
- RES_LAT = 0 and RES_LAT = 3 variants of the first scenario -> same counts, with the pulse offsets matching each latency.
